// File: rtl/keypad_scan_pkg.sv
// Shared defaults, frame-result and commit-state encodings for the keypad scanner.
package keypad_scan_pkg;

  localparam int DEF_ROWS       = 4;
  localparam int DEF_COLS       = 4;
  localparam int DEF_SCAN_DIV   = 50000;
  localparam int DEF_DEB_FRAMES = 4;

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } frame_res_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DOWN = 2'd1,
    ST_PEND = 2'd2
  } commit_st_e;

  // Pressed-key counts only need to distinguish 0, 1 and "2 or more".
  function automatic logic [1:0] sat2_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd2) ? 2'd2 : s[1:0];
  endfunction

  function automatic frame_res_e classify(input logic [1:0] cnt);
    case (cnt)
      2'd0:    return RES_NONE;
      2'd1:    return RES_SINGLE;
      default: return RES_MULTI;
    endcase
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad scanner signal bundle: user/pin side drives en and col_n, scanner drives the rest.
interface keypad_scan_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  localparam int CW = $clog2(ROWS * COLS);

  logic            en;
  logic [COLS-1:0] col_n;
  logic [ROWS-1:0] row_n;
  logic [CW-1:0]   key_code;
  logic            key_valid;
  logic            key_down;
  logic            key_release;

  modport master (
    output en, col_n,
    input  row_n, key_code, key_valid, key_down, key_release
  );

  modport slave (
    input  en, col_n,
    output row_n, key_code, key_valid, key_down, key_release
  );
endinterface

// File: rtl/keypad_scan_sync_2ff.sv
// Two-flop synchronizer; resets to all ones so idle pulled-up lines read as released.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/keypad_scan.sv
// Matrix keypad reader: row scan, per-frame key classification, frame debounce, commit FSM.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int SCAN_DIV   = DEF_SCAN_DIV,
  parameter int DEB_FRAMES = DEF_DEB_FRAMES
) (
  input logic          CLOCK_50,
  input logic          rst,
  keypad_scan_if.slave kp
);
  localparam int CW = $clog2(ROWS * COLS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int RW = $clog2(ROWS);
  localparam int SW = 4;

  logic [COLS-1:0] w_col_s;
  logic [COLS-1:0] w_pressed;
  logic [DW-1:0]   r_dwell;
  logic [RW-1:0]   r_row;
  logic            r_run;
  logic [1:0]      r_acc_cnt;
  logic [CW-1:0]   r_acc_code;
  frame_res_e      r_prev_res;
  logic [CW-1:0]   r_prev_code;
  logic [SW-1:0]   r_stable;

  logic            w_scan, w_last_dwell, w_sample, w_frame_end, w_same, w_commit;
  logic [1:0]      w_row_hits, w_cnt;
  logic [CW-1:0]   w_row_code, w_code, w_res_code;
  frame_res_e      w_res;
  logic [SW-1:0]   w_stable_nxt;

  commit_st_e      r_st, w_st_nxt;
  logic [CW-1:0]   r_key_code, w_code_nxt;
  logic [CW-1:0]   r_pend_code, w_pend_nxt;
  logic            r_key_valid, w_valid_nxt;
  logic            r_key_release, w_rel_nxt;

  sync_2ff #(.W(COLS)) u_col_sync (
    .i_clk (CLOCK_50),
    .i_rst (rst),
    .i_d   (kp.col_n),
    .o_q   (w_col_s)
  );

  assign w_pressed    = ~w_col_s;
  // r_run keeps rows released for the first cycle out of reset so row 0 gets a full dwell.
  assign w_scan       = kp.en & r_run;
  assign w_last_dwell = (r_dwell == DW'(SCAN_DIV - 1));
  assign w_sample     = w_scan & w_last_dwell;
  assign w_frame_end  = w_sample & (r_row == RW'(ROWS - 1));

  always_comb begin
    w_row_hits = 2'd0;
    w_row_code = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (w_pressed[c]) w_row_code = CW'(int'(r_row) * COLS + c);
    end
    for (int c = 0; c < COLS; c++) begin
      w_row_hits = sat2_add(w_row_hits, {1'b0, w_pressed[c]});
    end
    w_cnt      = sat2_add(r_acc_cnt, w_row_hits);
    w_code     = (r_acc_cnt == 2'd0) ? w_row_code : r_acc_code;
    w_res      = classify(w_cnt);
    // Code is zeroed for NONE/MULTI so result comparison ignores stale codes.
    w_res_code = (w_res == RES_SINGLE) ? w_code : '0;
    w_same     = (w_res == r_prev_res) && (w_res_code == r_prev_code);
    if (!w_same)                           w_stable_nxt = SW'(1);
    else if (r_stable == SW'(DEB_FRAMES))  w_stable_nxt = r_stable;
    else                                   w_stable_nxt = r_stable + SW'(1);
    w_commit = w_frame_end && (w_stable_nxt == SW'(DEB_FRAMES)) &&
               !(w_same && (r_stable == SW'(DEB_FRAMES)));
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      r_run       <= 1'b0;
      r_dwell     <= '0;
      r_row       <= '0;
      r_acc_cnt   <= 2'd0;
      r_acc_code  <= '0;
      r_prev_res  <= RES_NONE;
      r_prev_code <= '0;
      r_stable    <= '0;
    end else begin
      r_run <= 1'b1;
      if (!kp.en) begin
        r_dwell     <= '0;
        r_row       <= '0;
        r_acc_cnt   <= 2'd0;
        r_acc_code  <= '0;
        r_prev_res  <= RES_NONE;
        r_prev_code <= '0;
        r_stable    <= '0;
      end else if (r_run) begin
        if (w_last_dwell) begin
          r_dwell <= '0;
          r_row   <= (r_row == RW'(ROWS - 1)) ? '0 : r_row + RW'(1);
        end else begin
          r_dwell <= r_dwell + DW'(1);
        end
        if (w_frame_end) begin
          r_acc_cnt   <= 2'd0;
          r_acc_code  <= '0;
          r_prev_res  <= w_res;
          r_prev_code <= w_res_code;
          r_stable    <= w_stable_nxt;
        end else if (w_sample) begin
          r_acc_cnt  <= w_cnt;
          r_acc_code <= w_code;
        end
      end
    end
  end

  // Key switch goes DOWN -> PEND (release pulse) -> DOWN (valid pulse) so the pulses never overlap.
  always_comb begin
    w_st_nxt    = r_st;
    w_code_nxt  = r_key_code;
    w_pend_nxt  = r_pend_code;
    w_valid_nxt = 1'b0;
    w_rel_nxt   = 1'b0;
    if (!kp.en) begin
      w_st_nxt = ST_IDLE;
    end else begin
      case (r_st)
        ST_IDLE: begin
          if (w_commit && (w_res == RES_SINGLE)) begin
            w_st_nxt    = ST_DOWN;
            w_code_nxt  = w_res_code;
            w_valid_nxt = 1'b1;
          end
        end
        ST_DOWN: begin
          if (w_commit && (w_res == RES_NONE)) begin
            w_st_nxt  = ST_IDLE;
            w_rel_nxt = 1'b1;
          end else if (w_commit && (w_res == RES_SINGLE) && (w_res_code != r_key_code)) begin
            w_st_nxt   = ST_PEND;
            w_rel_nxt  = 1'b1;
            w_pend_nxt = w_res_code;
          end
        end
        ST_PEND: begin
          w_st_nxt    = ST_DOWN;
          w_code_nxt  = r_pend_code;
          w_valid_nxt = 1'b1;
        end
        default: w_st_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      r_st          <= ST_IDLE;
      r_key_code    <= '0;
      r_pend_code   <= '0;
      r_key_valid   <= 1'b0;
      r_key_release <= 1'b0;
    end else begin
      r_st          <= w_st_nxt;
      r_key_code    <= w_code_nxt;
      r_pend_code   <= w_pend_nxt;
      r_key_valid   <= w_valid_nxt;
      r_key_release <= w_rel_nxt;
    end
  end

  assign kp.row_n       = w_scan ? ~(ROWS'(1) << r_row) : '1;
  assign kp.key_code    = r_key_code;
  assign kp.key_valid   = r_key_valid;
  assign kp.key_release = r_key_release;
  assign kp.key_down    = (r_st == ST_DOWN);

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: directed vectors, multi-cycle corner cases and randomized key sets.
module tb_keypad_scan;
  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int FRAME    = ROWS * SCAN_DIV;
  localparam int LAT_MAX  = (DEB + 1) * FRAME + 4;

  logic        CLOCK_50 = 1'b0;
  logic        rst;
  logic [15:0] keys;

  keypad_scan_if #(.ROWS(ROWS), .COLS(COLS)) kp ();

  keypad_scan #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEB_FRAMES(DEB)) dut (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .kp       (kp)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Keypad: a pressed switch shorts its column to its row while that row is driven low.
  always_comb begin
    kp.col_n = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys[r*COLS+c] && !kp.row_n[r]) kp.col_n[c] = 1'b0;
  end

  typedef struct { bit is_valid; int code; } ev_t;
  ev_t obs_q[$];
  int  n_val = 0, n_rel = 0, n_both = 0;

  always @(negedge CLOCK_50) begin
    if (kp.key_valid) begin
      n_val <= n_val + 1;
      obs_q.push_back('{1'b1, int'(kp.key_code)});
    end
    if (kp.key_release) begin
      n_rel <= n_rel + 1;
      obs_q.push_back('{1'b0, 0});
    end
    if (kp.key_valid && kp.key_release) n_both <= n_both + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic nx();
    @(negedge CLOCK_50);
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) nx();
  endtask

  // Frame result from the key set: 0 none, 1 single (code = lowest row, then lowest col), 2 multi.
  function automatic int classify_keys(input logic [15:0] k, output int code);
    int n;
    n    = $countones(k);
    code = 0;
    for (int i = 15; i >= 0; i--) if (k[i]) code = i;
    return (n == 0) ? 0 : (n == 1) ? 1 : 2;
  endfunction

  typedef struct {
    logic [15:0] keys;
    int          cycles;
    int          exp_val;
    int          exp_rel;
    int          exp_code;
    int          exp_down;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    int   v0, r0, t0, rel_cyc, val_cyc, vcode, found, seen;
    int   m_down, m_code, res, code, rstart, nexp;
    ev_t  exp_q[$];

    vt[0] = '{16'h0200, 80, 1, 0,  9, 1};
    vt[1] = '{16'h0000, 80, 0, 1,  9, 0};
    vt[2] = '{16'h0021, 80, 0, 0,  9, 0};
    vt[3] = '{16'h8000, 80, 1, 0, 15, 1};
    vt[4] = '{16'h8001, 80, 0, 0, 15, 1};
    vt[5] = '{16'h0200, 80, 1, 1,  9, 1};
    vt[6] = '{16'h0008, 80, 1, 1,  3, 1};
    vt[7] = '{16'h0000, 80, 0, 1,  3, 0};

    // Reset state and row scan order
    rst = 1'b1; kp.en = 1'b1; keys = '0;
    hold(3);
    check("rst_row_n", kp.row_n, 4'b1111);
    check("rst_code", kp.key_code, 0);
    check("rst_valid", kp.key_valid, 0);
    check("rst_down", kp.key_down, 0);
    check("rst_release", kp.key_release, 0);
    rst = 1'b0;
    found = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      nx();
      if (kp.row_n == 4'b1110) found = 1;
    end
    check("scan_start", found, 1);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("scan_row_c%0d", i), kp.row_n, int'(~(4'b0001 << ((i / 4) % 4)) & 4'hF));
      nx();
    end

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      v0 = n_val; r0 = n_rel;
      keys = vt[i].keys;
      hold(vt[i].cycles);
      check($sformatf("vec%0d_valid_pulses", i), n_val - v0, vt[i].exp_val);
      check($sformatf("vec%0d_release_pulses", i), n_rel - r0, vt[i].exp_rel);
      check($sformatf("vec%0d_code", i), kp.key_code, vt[i].exp_code);
      check($sformatf("vec%0d_down", i), kp.key_down, vt[i].exp_down);
    end

    // Bounce: phase the 20-cycle toggle against row 2 so no two row-2 samples see the key
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      nx();
      if (kp.row_n == 4'b1101) found = 1;
    end
    seen = 0;
    for (int i = 0; i < 8 && found && !seen; i++) begin
      nx();
      if (kp.row_n == 4'b1011) seen = 1;
    end
    check("bounce_align", seen, 1);
    hold(3);
    v0 = n_val;
    for (int i = 0; i < 10; i++) begin
      keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
      hold(20);
    end
    check("bounce_no_valid", n_val - v0, 0);
    v0 = n_val;
    keys = 16'h0200;
    hold(80);
    check("bounce_then_hold_valid", n_val - v0, 1);
    check("bounce_then_hold_code", kp.key_code, 9);

    // Switch (2,1) -> (0,3): release in cycle N, valid in N+1
    keys = 16'h0008;
    t0 = 0; rel_cyc = -1; val_cyc = -1; vcode = -1;
    while (t0 < 100 && val_cyc < 0) begin
      nx(); t0++;
      if (kp.key_release && rel_cyc < 0) rel_cyc = t0;
      if (kp.key_valid) begin val_cyc = t0; vcode = int'(kp.key_code); end
    end
    check("switch_release_seen", (rel_cyc > 0 && rel_cyc <= LAT_MAX) ? 1 : 0, 1);
    check("switch_valid_next_cycle", val_cyc - rel_cyc, 1);
    check("switch_code", vcode, 3);
    check("switch_down", kp.key_down, 1);
    keys = 16'h0200;
    hold(80);
    check("back_to_21_code", kp.key_code, 9);

    // Asynchronous reset mid-press
    #3 rst = 1'b1;
    #1;
    check("async_rst_row_n", kp.row_n, 4'b1111);
    check("async_rst_down", kp.key_down, 0);
    check("async_rst_code", kp.key_code, 0);
    nx();
    rst = 1'b0;
    v0 = n_val;
    hold(80);
    check("after_rst_recommit", n_val - v0, 1);
    check("after_rst_down", kp.key_down, 1);

    // en low while down: rows released, no release pulse
    r0 = n_rel;
    kp.en = 1'b0;
    hold(3);
    check("en_low_row_n", kp.row_n, 4'b1111);
    check("en_low_down", kp.key_down, 0);
    check("en_low_no_release", n_rel - r0, 0);
    kp.en = 1'b1;
    #1;
    check("en_restart_row0", kp.row_n, 4'b1110);
    v0 = n_val;
    hold(80);
    check("en_restart_recommit", n_val - v0, 1);

    // en dropped between release and new-key pulses drops the pending press
    keys = 16'h0008;
    found = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      nx();
      if (kp.key_release) begin
        kp.en = 1'b0;
        found = 1;
      end
    end
    check("pend_release_seen", found, 1);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      nx();
      if (kp.key_valid) seen++;
    end
    check("pend_dropped_valid", seen, 0);
    check("pend_dropped_down", kp.key_down, 0);

    // Randomized key sets against the commit-table model
    keys = '0;
    kp.en = 1'b1;
    hold(40);
    rstart = obs_q.size();
    m_down = 0; m_code = 0;
    for (int s = 0; s < 25; s++) begin
      int sel, b0, b1;
      sel = $urandom_range(0, 9);
      b0  = $urandom_range(0, 15);
      b1  = (b0 + $urandom_range(1, 15)) % 16;
      if (sel < 3)      keys = '0;
      else if (sel < 8) keys = 16'(1) << b0;
      else              keys = (16'(1) << b0) | (16'(1) << b1);
      res = classify_keys(keys, code);
      if (!m_down && res == 1) begin
        exp_q.push_back('{1'b1, code}); m_down = 1; m_code = code;
      end else if (m_down && res == 0) begin
        exp_q.push_back('{1'b0, 0}); m_down = 0;
      end else if (m_down && res == 1 && code != m_code) begin
        exp_q.push_back('{1'b0, 0}); exp_q.push_back('{1'b1, code}); m_code = code;
      end
      hold($urandom_range(70, 160));
      check($sformatf("rand%0d_down", s), kp.key_down, m_down);
      if (m_down) check($sformatf("rand%0d_code", s), kp.key_code, m_code);
    end
    nexp = exp_q.size();
    check("rand_event_count", obs_q.size() - rstart, nexp);
    for (int i = 0; i < nexp && (rstart + i) < obs_q.size(); i++) begin
      check($sformatf("rand_ev%0d_kind", i), obs_q[rstart+i].is_valid, exp_q[i].is_valid);
      check($sformatf("rand_ev%0d_code", i), obs_q[rstart+i].code, exp_q[i].code);
    end

    check("valid_release_overlap", n_both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
